// File: rtl/reservation_station_pkg.sv
// Shared widths, op codes and payload types for the integer-ALU reservation station.
package reservation_station_pkg;

  localparam int unsigned OP_WIDTH     = 7;
  localparam int unsigned VAL_WIDTH    = 32;
  localparam int unsigned ROB_ID_WIDTH = 4;
  localparam int unsigned ADDR_WIDTH   = 32;

  localparam logic [OP_WIDTH-1:0] OP_ADD_TYPE  = 7'd1;
  localparam logic [OP_WIDTH-1:0] OP_ADDI_TYPE = 7'd2;
  localparam logic [OP_WIDTH-1:0] OP_SUB_TYPE  = 7'd3;
  localparam logic [OP_WIDTH-1:0] OP_AND_TYPE  = 7'd4;
  localparam logic [OP_WIDTH-1:0] OP_OR_TYPE   = 7'd5;
  localparam logic [OP_WIDTH-1:0] OP_XOR_TYPE  = 7'd6;
  localparam logic [OP_WIDTH-1:0] OP_SLL_TYPE  = 7'd7;
  localparam logic [OP_WIDTH-1:0] OP_SRL_TYPE  = 7'd8;

  typedef struct packed {
    logic                    valid;
    logic [ROB_ID_WIDTH-1:0] tag;
    logic [VAL_WIDTH-1:0]    val;
  } cdb_t;

  typedef struct packed {
    logic                    pend;
    logic [ROB_ID_WIDTH-1:0] tag;
    logic [VAL_WIDTH-1:0]    val;
  } opnd_t;

  typedef struct packed {
    logic                    busy;
    logic [OP_WIDTH-1:0]     op_type;
    opnd_t                   j;
    opnd_t                   k;
    logic [ROB_ID_WIDTH-1:0] rob;
    logic [ADDR_WIDTH-1:0]   pc;
  } rs_entry_t;

  // Capture a broadcast value into a pending operand; the ALU bus wins a tag tie.
  function automatic opnd_t snoop(opnd_t cur, cdb_t alu, cdb_t lsb);
    opnd_t res;
    res = cur;
    if (cur.pend && alu.valid && (alu.tag == cur.tag)) begin
      res.pend = 1'b0;
      res.val  = alu.val;
    end else if (cur.pend && lsb.valid && (lsb.tag == cur.tag)) begin
      res.pend = 1'b0;
      res.val  = lsb.val;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic                    disp_valid;
  logic [OP_WIDTH-1:0]     disp_type;
  logic [VAL_WIDTH-1:0]    disp_vj;
  logic [VAL_WIDTH-1:0]    disp_vk;
  logic                    disp_qj_pend;
  logic                    disp_qk_pend;
  logic [ROB_ID_WIDTH-1:0] disp_qj;
  logic [ROB_ID_WIDTH-1:0] disp_qk;
  logic [ROB_ID_WIDTH-1:0] disp_entry;
  logic [ADDR_WIDTH-1:0]   disp_pc;

  logic                    alu_cdb_valid;
  logic [ROB_ID_WIDTH-1:0] alu_cdb_entry;
  logic [VAL_WIDTH-1:0]    alu_cdb_val;
  logic                    lsb_cdb_valid;
  logic [ROB_ID_WIDTH-1:0] lsb_cdb_entry;
  logic [VAL_WIDTH-1:0]    lsb_cdb_val;

  logic                    rs_full;
  logic                    execute;
  logic [OP_WIDTH-1:0]     op_type;
  logic [VAL_WIDTH-1:0]    val1;
  logic [VAL_WIDTH-1:0]    val2;
  logic [ROB_ID_WIDTH-1:0] entry;
  logic [ADDR_WIDTH-1:0]   nowPC;

  modport master (
    output disp_valid, disp_type, disp_vj, disp_vk, disp_qj_pend, disp_qk_pend,
           disp_qj, disp_qk, disp_entry, disp_pc,
           alu_cdb_valid, alu_cdb_entry, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_val,
    input  rs_full, execute, op_type, val1, val2, entry, nowPC
  );

  modport slave (
    input  disp_valid, disp_type, disp_vj, disp_vk, disp_qj_pend, disp_qk_pend,
           disp_qj, disp_qk, disp_entry, disp_pc,
           alu_cdb_valid, alu_cdb_entry, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_val,
    output rs_full, execute, op_type, val1, val2, entry, nowPC
  );

endinterface

// File: rtl/reservation_station_rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and the lowest one.
module rs_pick #(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Integer-ALU reservation station: buffers dispatched ops, snoops two result buses,
// and issues the lowest-index operand-ready op to the ALU through registered outputs.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  reservation_station_if.slave  rs
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  rs_entry_t          ents     [RS_SIZE];
  rs_entry_t          ents_nxt [RS_SIZE];
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               issue_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   issue_idx;
  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;

  logic                    execute_q;
  logic [OP_WIDTH-1:0]     op_type_q;
  logic [VAL_WIDTH-1:0]    val1_q;
  logic [VAL_WIDTH-1:0]    val2_q;
  logic [ROB_ID_WIDTH-1:0] entry_q;
  logic [ADDR_WIDTH-1:0]   pc_q;

  assign alu_cdb = '{valid: rs.alu_cdb_valid, tag: rs.alu_cdb_entry, val: rs.alu_cdb_val};
  assign lsb_cdb = '{valid: rs.lsb_cdb_valid, tag: rs.lsb_cdb_entry, val: rs.lsb_cdb_val};

  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i]  = ~ents[i].busy;
      ready_vec[i] = ents[i].busy & ~ents[i].j.pend & ~ents[i].k.pend;
    end
  end

  rs_pick #(.N(RS_SIZE)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE)) u_ready_pick (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );

  // Next entry state from pre-edge selections; issue, wakeup and dispatch touch disjoint slots.
  always_comb begin
    ents_nxt = ents;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (ents[i].busy) begin
        ents_nxt[i].j = snoop(ents[i].j, alu_cdb, lsb_cdb);
        ents_nxt[i].k = snoop(ents[i].k, alu_cdb, lsb_cdb);
      end
    end
    if (issue_found) begin
      ents_nxt[issue_idx].busy = 1'b0;
    end
    if (rs.disp_valid && free_found) begin
      ents_nxt[free_idx].busy    = 1'b1;
      ents_nxt[free_idx].op_type = rs.disp_type;
      ents_nxt[free_idx].j       = snoop(opnd_t'{pend: rs.disp_qj_pend, tag: rs.disp_qj,
                                                 val: rs.disp_vj}, alu_cdb, lsb_cdb);
      ents_nxt[free_idx].k       = snoop(opnd_t'{pend: rs.disp_qk_pend, tag: rs.disp_qk,
                                                 val: rs.disp_vk}, alu_cdb, lsb_cdb);
      ents_nxt[free_idx].rob     = rs.disp_entry;
      ents_nxt[free_idx].pc      = rs.disp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ents[i] <= '0;
      end
      execute_q <= 1'b0;
      op_type_q <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      entry_q   <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ents[i].busy <= 1'b0;
      end
      execute_q <= 1'b0;
    end else if (rdy_in) begin
      ents      <= ents_nxt;
      execute_q <= issue_found;
      if (issue_found) begin
        op_type_q <= ents[issue_idx].op_type;
        val1_q    <= ents[issue_idx].j.val;
        val2_q    <= ents[issue_idx].k.val;
        entry_q   <= ents[issue_idx].rob;
        pc_q      <= ents[issue_idx].pc;
      end
    end
  end

  assign rs.rs_full = &(~free_vec);
  assign rs.execute = execute_q;
  assign rs.op_type = op_type_q;
  assign rs.val1    = val1_q;
  assign rs.val2    = val2_q;
  assign rs.entry   = entry_q;
  assign rs.nowPC   = pc_q;

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Integer-ALU reservation station; sits between decoder/dispatch and the ALU, directly upstream of it.
- Buffers dispatched ops and captures operand values from two result broadcast buses: ALU writeback and load/store writeback.
- Selects one operand-ready op per cycle and presents it to the ALU as a registered issue.
- Reports full to dispatch; cleared on misprediction flush.

Parameters:
RS_SIZE, 8, number of entries (power of two, >=2)
OP_WIDTH, 7, op type code width (shared constant)
VAL_WIDTH, 32, operand/result width
ROB_ID_WIDTH, 4, ROB tag width
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low = freeze all state
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch request this cycle
disp_type  in  OP_WIDTH  op type code
disp_vj / disp_vk  in  VAL_WIDTH  operand values (meaningful when not pending)
disp_qj_pend / disp_qk_pend  in  1  operand awaits a ROB tag
disp_qj / disp_qk  in  ROB_ID_WIDTH  producer tags
disp_entry  in  ROB_ID_WIDTH  destination ROB tag
disp_pc  in  ADDR_WIDTH  instruction PC
alu_cdb_valid / alu_cdb_entry / alu_cdb_val  in  1/ROB_ID_WIDTH/VAL_WIDTH  ALU broadcast
lsb_cdb_valid / lsb_cdb_entry / lsb_cdb_val  in  1/ROB_ID_WIDTH/VAL_WIDTH  load/store broadcast
rs_full  out  1  no free entry
execute  out  1  issue strobe to ALU
type  out  OP_WIDTH  issued op type
val1 / val2  out  VAL_WIDTH  issued operands
entry  out  ROB_ID_WIDTH  issued ROB tag
nowPC  out  ADDR_WIDTH  issued PC

Behaviour:
- Reset (rst_n_in low, asynchronous): every entry not busy; execute, type, val1, val2, entry and nowPC all 0; rs_full 0.
- Priority on each posedge: reset, then flush, then !rdy_in, then normal operation.
- Flush: clear all busy bits and set execute to 0 on that edge. Same-edge dispatch and CDB captures are discarded.
- !rdy_in: all state and outputs hold, including a held execute=1. The ALU consumes the held issue once rdy_in returns.
- Entry fields: busy, type, vj, vk, qj, qk, qj_pend, qk_pend, rob, pc.
  - An entry is ready when busy and both pend flags are clear.
- Dispatch:
  - When disp_valid and !rs_full, write the lowest-index non-busy entry. Selection uses pre-edge state, so a slot freed by issue on the same edge is not reused.
  - disp_valid while rs_full is ignored; dispatch must not do this, and the bench asserts against it.
- Dispatch bypass: if a dispatched operand is pending and its tag equals a valid CDB tag on the same edge, store the CDB value and clear pend.
  - If both CDBs carry the same tag, ALU wins.
- Wakeup: on each edge, every busy entry with a pending operand whose tag matches a valid CDB captures that value and clears pend.
  - The entry becomes issue-eligible on the following edge. There is no combinational wakeup-to-issue path.
- Issue:
  - On each edge, pick the lowest-index ready entry from pre-edge state.
  - If found: execute<=1, load type/val1=vj/val2=vk/entry=rob/nowPC=pc from it, and clear its busy bit.
  - If none: execute<=0; the other outputs hold their last values.
  - One issue per cycle.
- Latency: an op dispatched with no pending operands on edge N shows execute=1 after edge N+1. The ALU result appears after edge N+2.
  - An op woken on edge M issues on edge M+1.
- rs_full: combinational, true when all RS_SIZE entries are busy.
- Simultaneous events in one cycle: issue, dispatch and wakeup of different entries are independent.
  - Wakeup of an entry being issued cannot happen, because an issued entry has no pending operands.

Decomposition:
- Shared header util.v holds OP_WIDTH, VAL_WIDTH, ROB_ID_WIDTH, ADDR_WIDTH and the OP_*_TYPE codes.
- One sub-module, rs_pick: a parameterised lowest-index priority encoder returning found and index. Instantiate it twice, once for the free slot and once for the ready slot.

Test Plan:
1. Reset mid-operation: with 3 busy entries and execute=1, pull rst_n_in low between edges -> outputs go to 0 immediately and rs_full=0; after release, no issue occurs until a new dispatch.
2. Ready dispatch: addi, vj=5, vk=7, entry=3 on edge 0 -> after edge 1, execute=1, val1=5, val2=7, entry=3; after edge 2, execute=0.
3. Wakeup: dispatch with qj_pend, qj=2, vk=1; alu_cdb(2, 0x10) arrives 3 cycles later -> issue follows on the next edge with val1=0x10, val2=1.
4. Dispatch bypass with conflict: dispatch qj=6 on the same edge as alu_cdb(6, 9) and lsb_cdb(6, 4) -> the entry stores 9 and issues on the next edge.
5. Full and ordering: fill 8 entries with pending ops, then check rs_full=1 and that a 9th dispatch is ignored. Broadcast tags waking entries 5 and 2 together -> entry 2 issues first, entry 5 one cycle later, then rs_full=0.
6. Flush and stall: flush with 4 busy entries -> execute=0 and no further issues. rdy_in low while execute=1 -> outputs are held unchanged for 5 cycles.
